// File: rtl/icache_ctrl_if.sv
// Fetch-side, SRAM-side and line-fill signals of the instruction cache controller.
// slave is the controller's view; master is the surrounding fetch/SRAM/memory side.
interface icache_ctrl_if #(
  parameter int unsigned SETS  = 16,
  parameter int unsigned WAYS  = 4,
  parameter int unsigned TAG_W = 23,
  parameter int unsigned OFF_W = 5
);
  localparam int unsigned SET_W = $clog2(SETS);

  logic [31:0]         ufp_addr;
  logic [3:0]          ufp_rmask;
  logic                ufp_flush;
  logic                ufp_ready;
  logic                ufp_resp;
  logic [1:0]          hit_way;
  logic [OFF_W-1:0]    resp_offset;
  logic [SET_W-1:0]    arr_set;
  logic [WAYS*TAG_W-1:0] tag_rdata;
  logic [WAYS-1:0]     tag_we;
  logic [WAYS-1:0]     data_we;
  logic [TAG_W-1:0]    tag_wdata;
  logic                dfp_read;
  logic [31:0]         dfp_addr;
  logic                dfp_resp;

  modport slave (
    input  ufp_addr, ufp_rmask, ufp_flush, tag_rdata, dfp_resp,
    output ufp_ready, ufp_resp, hit_way, resp_offset, arr_set,
           tag_we, data_we, tag_wdata, dfp_read, dfp_addr
  );

  modport master (
    output ufp_addr, ufp_rmask, ufp_flush, tag_rdata, dfp_resp,
    input  ufp_ready, ufp_resp, hit_way, resp_offset, arr_set,
           tag_we, data_we, tag_wdata, dfp_read, dfp_addr
  );
endinterface

// File: rtl/icache_ctrl.sv
// 4-way set-associative instruction cache controller: request stage, tag compare,
// valid/PLRU state and the pass-through / allocate / allocate-stall miss sequencer.
module icache_ctrl #(
  parameter int unsigned SETS  = 16,
  parameter int unsigned WAYS  = 4,
  parameter int unsigned TAG_W = 23,
  parameter int unsigned OFF_W = 5
) (
  input logic          clk,
  input logic          rst_n,
  icache_ctrl_if.slave bus
);
  localparam int unsigned SET_W = $clog2(SETS);

  typedef enum logic [1:0] {StPassThru, StAllocate, StAllocateStall} state_e;

  state_e                     r_state;
  logic                       r_stage_valid;
  logic [TAG_W-1:0]           r_stage_tag;
  logic [SET_W-1:0]           r_stage_set;
  logic [OFF_W-1:0]           r_stage_off;
  logic [1:0]                 r_victim;
  logic                       r_drop_pending;
  logic                       r_dfp_read;
  logic [SETS-1:0][WAYS-1:0]  r_valid;
  logic [SETS-1:0][2:0]       r_plru;

  logic [WAYS-1:0] w_hit_vec;
  logic [WAYS-1:0] w_set_valid;
  logic [WAYS-1:0] w_fill_we;
  logic [2:0]      w_set_plru;
  logic [1:0]      w_hit_way;
  logic [1:0]      w_new_victim;
  logic            w_pass;
  logic            w_any_hit;
  logic            w_miss;
  logic            w_ready;
  logic            w_accept;
  logic            w_resp;
  logic            w_fill;

  // Tree PLRU: each bit is moved to point away from the way just touched.
  function automatic logic [2:0] plru_touch(input logic [2:0] bits, input logic [1:0] way);
    logic [2:0] nxt;
    nxt    = bits;
    nxt[0] = ~way[1];
    if (way[1]) nxt[2] = ~way[0];
    else        nxt[1] = ~way[0];
    return nxt;
  endfunction

  assign w_set_valid = r_valid[r_stage_set];
  assign w_set_plru  = r_plru[r_stage_set];

  always_comb begin
    for (int w = 0; w < WAYS; w++) begin
      w_hit_vec[w] = w_set_valid[w] && (bus.tag_rdata[w*TAG_W +: TAG_W] == r_stage_tag);
    end
  end

  always_comb begin
    w_hit_way = 2'd0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (w_hit_vec[w]) w_hit_way = 2'(w);
    end
  end

  // Lowest invalid way wins over the PLRU choice.
  always_comb begin
    if (!w_set_plru[0]) w_new_victim = w_set_plru[1] ? 2'd1 : 2'd0;
    else                w_new_victim = w_set_plru[2] ? 2'd3 : 2'd2;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!w_set_valid[w]) w_new_victim = 2'(w);
    end
  end

  assign w_pass    = (r_state == StPassThru);
  assign w_any_hit = |w_hit_vec;
  // A flush discards the staged request, so it can neither hit nor miss.
  assign w_miss    = w_pass && r_stage_valid && !w_any_hit && !bus.ufp_flush;
  assign w_resp    = w_pass && r_stage_valid && w_any_hit && !bus.ufp_flush;
  assign w_ready   = w_pass && !w_miss;
  assign w_accept  = w_ready && (bus.ufp_rmask != 4'd0);
  assign w_fill    = (r_state == StAllocate) && bus.dfp_resp;
  assign w_fill_we = w_fill ? (WAYS'(1) << r_victim) : '0;

  assign bus.ufp_ready   = w_ready;
  assign bus.ufp_resp    = w_resp;
  assign bus.hit_way     = w_hit_way;
  assign bus.resp_offset = r_stage_off;
  assign bus.arr_set     = w_ready ? bus.ufp_addr[OFF_W +: SET_W] : r_stage_set;
  assign bus.tag_we      = w_fill_we;
  assign bus.data_we     = w_fill_we;
  assign bus.tag_wdata   = r_stage_tag;
  assign bus.dfp_read    = r_dfp_read;
  assign bus.dfp_addr    = {r_stage_tag, r_stage_set, {OFF_W{1'b0}}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= StPassThru;
      r_stage_valid  <= 1'b0;
      r_stage_tag    <= '0;
      r_stage_set    <= '0;
      r_stage_off    <= '0;
      r_victim       <= 2'd0;
      r_drop_pending <= 1'b0;
      r_dfp_read     <= 1'b0;
      r_valid        <= '0;
      r_plru         <= '0;
    end else begin
      unique case (r_state)
        StPassThru: begin
          if (w_resp) r_plru[r_stage_set] <= plru_touch(w_set_plru, w_hit_way);
          if (w_miss) begin
            r_victim   <= w_new_victim;
            r_dfp_read <= 1'b1;
            r_state    <= StAllocate;
          end else if (w_accept) begin
            r_stage_valid <= 1'b1;
            r_stage_tag   <= bus.ufp_addr[31 -: TAG_W];
            r_stage_set   <= bus.ufp_addr[OFF_W +: SET_W];
            r_stage_off   <= bus.ufp_addr[OFF_W-1:0];
          end else begin
            r_stage_valid <= 1'b0;
          end
        end
        StAllocate: begin
          if (bus.ufp_flush) r_drop_pending <= 1'b1;
          if (bus.dfp_resp) begin
            r_valid[r_stage_set][r_victim] <= 1'b1;
            r_plru[r_stage_set]            <= plru_touch(w_set_plru, r_victim);
            r_dfp_read                     <= 1'b0;
            r_state                        <= StAllocateStall;
          end
        end
        StAllocateStall: begin
          // Staged request survives so the re-read tag produces the hit next cycle.
          if (r_drop_pending || bus.ufp_flush) r_stage_valid <= 1'b0;
          r_drop_pending <= 1'b0;
          r_state        <= StPassThru;
        end
        default: r_state <= StPassThru;
      endcase
    end
  end
endmodule

// File: tb/tb_icache_ctrl.sv
// Scoreboard bench for icache_ctrl with tag SRAM and line-fill memory models.
module tb_icache_ctrl;
  localparam int FILL_LAT = 5;

  typedef struct packed {
    logic [1:0] way;
    logic [4:0] off;
  } resp_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  we;
  } fill_t;

  logic clk;
  logic rst_n;
  int   n_total = 0;
  int   n_bad   = 0;
  int   cyc     = 0;
  int   resp_seen = 0;
  int   fill_seen = 0;
  int   last_resp_cyc = 0;
  int   last_fill_cyc = 0;

  resp_t exp_resp[$];
  fill_t exp_fill[$];

  icache_ctrl_if bus ();

  icache_ctrl u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Tag SRAM: registered read, read-before-write.
  initial begin
    logic [22:0] tag_mem [16][4];
    for (int s = 0; s < 16; s++) for (int w = 0; w < 4; w++) tag_mem[s][w] = '0;
    bus.tag_rdata <= '0;
    forever begin
      @(posedge clk);
      for (int w = 0; w < 4; w++) begin
        bus.tag_rdata[w*23 +: 23] <= tag_mem[bus.arr_set][w];
        if (bus.tag_we[w]) tag_mem[bus.arr_set][w] <= bus.tag_wdata;
      end
    end
  end

  // Line-fill memory: single-cycle dfp_resp on the FILL_LAT-th cycle of dfp_read.
  initial begin
    int lat_cnt;
    lat_cnt = 0;
    bus.dfp_resp = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.dfp_read && rst_n) begin
        lat_cnt++;
        bus.dfp_resp = (lat_cnt == FILL_LAT);
      end else begin
        lat_cnt = 0;
        bus.dfp_resp = 1'b0;
      end
    end
  end

  // Monitor: pops expectations whenever the DUT responds or writes a line.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.ufp_resp) begin
        resp_seen++;
        last_resp_cyc = cyc;
        if (exp_resp.size() == 0) begin
          chk("resp_unexpected", 32'(bus.ufp_resp), 32'd0);
        end else begin
          resp_t e;
          e = exp_resp.pop_front();
          chk("resp_way", 32'(bus.hit_way), 32'(e.way));
          chk("resp_offset", 32'(bus.resp_offset), 32'(e.off));
        end
      end
      if (bus.tag_we != 4'd0) begin
        fill_seen++;
        last_fill_cyc = cyc;
        if (exp_fill.size() == 0) begin
          chk("fill_unexpected", 32'(bus.tag_we), 32'd0);
        end else begin
          fill_t f;
          f = exp_fill.pop_front();
          chk("fill_tag_we", 32'(bus.tag_we), 32'(f.we));
          chk("fill_data_we", 32'(bus.data_we), 32'(f.we));
          chk("fill_tag_wdata", 32'(bus.tag_wdata), 32'(f.addr[31:9]));
          chk("fill_dfp_addr", bus.dfp_addr, f.addr);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_resp(input int target);
    int n;
    n = 0;
    do begin @(posedge clk); n++; end while (resp_seen < target && n < 60);
    #1;
    chk("resp_arrived", 32'(resp_seen >= target), 32'd1);
  endtask

  task automatic wait_fill(input int target);
    int n;
    n = 0;
    do begin @(posedge clk); n++; end while (fill_seen < target && n < 60);
    #1;
    chk("fill_arrived", 32'(fill_seen >= target), 32'd1);
  endtask

  // One fetch; a hit must respond the cycle after acceptance, a miss 2 cycles after fill.
  task automatic access(input logic [31:0] addr, input logic [1:0] way, input bit miss);
    int target;
    target = resp_seen + 1;
    exp_resp.push_back('{way: way, off: addr[4:0]});
    if (miss) exp_fill.push_back('{addr: addr & 32'hFFFF_FFE0, we: 4'b0001 << way});
    bus.ufp_addr  = addr;
    bus.ufp_rmask = 4'hF;
    tick();
    bus.ufp_rmask = 4'h0;
    if (!miss) begin
      @(negedge clk);
      chk("hit_latency1", 32'(bus.ufp_resp), 32'd1);
    end
    wait_resp(target);
    if (miss) chk("miss_latency", 32'(last_resp_cyc - last_fill_cyc), 32'd2);
  endtask

  initial begin
    int rs;
    int fs;
    logic [31:0] scan [4];
    scan = '{32'h0000_1040, 32'h0000_1448, 32'h0000_1A40, 32'h0000_30A4};

    rst_n         = 1'b0;
    bus.ufp_addr  = 32'h0;
    bus.ufp_rmask = 4'h0;
    bus.ufp_flush = 1'b0;
    #2;
    chk("rst_ready", 32'(bus.ufp_ready), 32'd1);
    chk("rst_resp", 32'(bus.ufp_resp), 32'd0);
    chk("rst_dfp_read", 32'(bus.dfp_read), 32'd0);
    chk("rst_tag_we", 32'(bus.tag_we), 32'd0);
    chk("rst_data_we", 32'(bus.data_we), 32'd0);
    #10;
    rst_n = 1'b1;
    tick();

    // Cold miss in set 2.
    exp_resp.push_back('{way: 2'd0, off: 5'd0});
    exp_fill.push_back('{addr: 32'h0000_1040, we: 4'b0001});
    bus.ufp_addr  = 32'h0000_1040;
    bus.ufp_rmask = 4'hF;
    tick();
    bus.ufp_rmask = 4'h0;
    @(negedge clk);
    chk("cold_ready_low", 32'(bus.ufp_ready), 32'd0);
    chk("cold_dfp_read_not_yet", 32'(bus.dfp_read), 32'd0);
    tick();
    @(negedge clk);
    chk("cold_dfp_read", 32'(bus.dfp_read), 32'd1);
    chk("cold_dfp_addr", bus.dfp_addr, 32'h0000_1040);
    wait_resp(1);
    chk("cold_miss_latency", 32'(last_resp_cyc - last_fill_cyc), 32'd2);

    // Back-to-back hits in the freshly filled line.
    rs = resp_seen;
    for (int i = 0; i < 3; i++) begin
      exp_resp.push_back('{way: 2'd0, off: 5'(i * 4)});
      bus.ufp_addr  = 32'h0000_1040 + 32'(i * 4);
      bus.ufp_rmask = 4'hF;
      @(negedge clk);
      chk("b2b_ready", 32'(bus.ufp_ready), 32'd1);
      chk("b2b_dfp_read", 32'(bus.dfp_read), 32'd0);
      if (i > 0) chk("b2b_resp", 32'(bus.ufp_resp), 32'd1);
      tick();
    end
    bus.ufp_rmask = 4'h0;
    @(negedge clk);
    chk("b2b_resp_last", 32'(bus.ufp_resp), 32'd1);
    tick();
    chk("b2b_resp_count", 32'(resp_seen - rs), 32'd3);

    // Fill set 2 in way order, then overflow it.
    access(32'h0000_1044, 2'd0, 1'b0);
    access(32'h0000_1244, 2'd1, 1'b1);
    access(32'h0000_1448, 2'd2, 1'b1);
    access(32'h0000_165C, 2'd3, 1'b1);
    access(32'h0000_1840, 2'd0, 1'b1);
    access(32'h0000_1040, 2'd2, 1'b1);

    // rmask = 0 is idle: no response, no fill, PLRU left alone.
    rs = resp_seen;
    fs = fill_seen;
    for (int i = 0; i < 4; i++) begin
      bus.ufp_addr  = scan[i];
      bus.ufp_rmask = 4'h0;
      tick();
      @(negedge clk);
      chk("idle_resp", 32'(bus.ufp_resp), 32'd0);
      chk("idle_dfp_read", 32'(bus.dfp_read), 32'd0);
    end
    tick();
    chk("idle_resp_count", 32'(resp_seen - rs), 32'd0);
    chk("idle_fill_count", 32'(fill_seen - fs), 32'd0);
    access(32'h0000_1A40, 2'd1, 1'b1);

    // Flush two cycles into ALLOCATE: line installed, no response.
    exp_fill.push_back('{addr: 32'h0000_30A0, we: 4'b0001});
    rs = resp_seen;
    fs = fill_seen;
    bus.ufp_addr  = 32'h0000_30A4;
    bus.ufp_rmask = 4'hF;
    tick();
    bus.ufp_rmask = 4'h0;
    tick();
    tick();
    bus.ufp_flush = 1'b1;
    tick();
    bus.ufp_flush = 1'b0;
    wait_fill(fs + 1);
    repeat (4) tick();
    chk("flush_no_resp", 32'(resp_seen - rs), 32'd0);
    access(32'h0000_30A4, 2'd0, 1'b0);

    // Hit coinciding with flush is dropped.
    rs = resp_seen;
    bus.ufp_addr  = 32'h0000_30A8;
    bus.ufp_rmask = 4'hF;
    tick();
    bus.ufp_rmask = 4'h0;
    bus.ufp_flush = 1'b1;
    @(negedge clk);
    chk("hitflush_resp", 32'(bus.ufp_resp), 32'd0);
    chk("hitflush_ready", 32'(bus.ufp_ready), 32'd1);
    tick();
    bus.ufp_flush = 1'b0;
    repeat (2) tick();
    chk("hitflush_resp_count", 32'(resp_seen - rs), 32'd0);

    // Reset in the middle of a fill.
    bus.ufp_addr  = 32'h0000_40E0;
    bus.ufp_rmask = 4'hF;
    tick();
    bus.ufp_rmask = 4'h0;
    tick();
    tick();
    @(negedge clk);
    chk("pre_rst_dfp_read", 32'(bus.dfp_read), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_dfp_read", 32'(bus.dfp_read), 32'd0);
    chk("async_rst_ready", 32'(bus.ufp_ready), 32'd1);
    chk("async_rst_tag_we", 32'(bus.tag_we), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    access(32'h0000_30A4, 2'd0, 1'b1);

    repeat (3) tick();
    chk("resp_queue_empty", 32'(exp_resp.size()), 32'd0);
    chk("fill_queue_empty", 32'(exp_fill.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end
endmodule
